// File: rtl/alu_issue_pkg.sv
// Shared widths, result-word layout, FSM state type and defaults for the
// ALU issue unit.
package alu_issue_pkg;

  localparam int OPC_W   = 4;
  localparam int OPND_W  = 8;
  localparam int INSTR_W = 20;
  localparam int RES_W   = 16;
  localparam int TAG_W   = 8;

  // Result word layout: {opcode, Y, C, V, N, Z}
  localparam int RES_OPC_LSB = 12;
  localparam int RES_Y_LSB   = 4;
  localparam int RES_C_BIT   = 3;
  localparam int RES_V_BIT   = 2;
  localparam int RES_N_BIT   = 1;
  localparam int RES_Z_BIT   = 0;

  localparam int DEFAULT_MAX_OP = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Assemble one result word from the issued opcode and the sampled ALU outputs.
  function automatic logic [RES_W-1:0] pack_result(
    input logic [OPC_W-1:0]  opc,
    input logic [OPND_W-1:0] y,
    input logic              c,
    input logic              v,
    input logic              n,
    input logic              z
  );
    logic [RES_W-1:0] r;
    r = '0;
    r[RES_OPC_LSB +: OPC_W] = opc;
    r[RES_Y_LSB +: OPND_W]  = y;
    r[RES_C_BIT]            = c;
    r[RES_V_BIT]            = v;
    r[RES_N_BIT]            = n;
    r[RES_Z_BIT]            = z;
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO, no fall-through: a pushed word is visible at the head
// from the cycle after the push. Pointers carry one extra wrap bit.
module alu_issue_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU instruction issue / result collection front end.
// Buffers host instructions, drives one at a time onto alu_instr, samples the
// ALU outputs after ALU_LAT cycles and queues {opcode, Y, C, V, N, Z}.
// Optional feature macro: ALU_ISSUE_TAG_EN adds an 8-bit sequence tag
// carried through both FIFOs and presented on out_tag.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 1,
  parameter int MAX_OP  = DEFAULT_MAX_OP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [INSTR_W-1:0] alu_instr,
  input  logic [OPND_W-1:0]  alu_y,
  input  logic               alu_c,
  input  logic               alu_v,
  input  logic               alu_n,
  input  logic               alu_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_data,
`ifdef ALU_ISSUE_TAG_EN
  output logic [TAG_W-1:0]   out_tag,
`endif
  output logic               busy,
  output logic               err_opcode,
  output logic [7:0]         drop_cnt,
  input  logic               clr_err
);

`ifdef ALU_ISSUE_TAG_EN
  localparam int IF_W = INSTR_W + TAG_W;
  localparam int RF_W = RES_W + TAG_W;
`else
  localparam int IF_W = INSTR_W;
  localparam int RF_W = RES_W;
`endif

  localparam logic [1:0]  LAT_M1   = 2'(ALU_LAT - 1);
  localparam logic [31:0] MAX_OP_U = 32'(MAX_OP);

  logic [IF_W-1:0]    w_if_din, w_if_head;
  logic               w_if_full, w_if_empty, w_if_push, w_if_pop;
  logic [RF_W-1:0]    w_rf_din, w_rf_head;
  logic               w_rf_full, w_rf_empty, w_rf_push, w_rf_pop;
  logic [INSTR_W-1:0] w_head_instr;
  logic [RES_W-1:0]   w_result;
  logic               w_legal, w_issue, w_drop, w_capture;
  state_t             r_state, w_state_nxt;
  logic [1:0]         r_cnt;
  logic [INSTR_W-1:0] r_alu_instr;
  logic               r_err;
  logic [7:0]         r_drop_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign w_if_push    = in_valid && in_ready;
  assign w_rf_pop     = out_valid && out_ready;
  assign w_rf_push    = w_capture;
  assign w_head_instr = w_if_head[INSTR_W-1:0];
  assign w_legal      = ({28'd0, w_head_instr[INSTR_W-1 -: OPC_W]} <= MAX_OP_U);
  assign w_result     = pack_result(r_alu_instr[INSTR_W-1 -: OPC_W], alu_y,
                                    alu_c, alu_v, alu_n, alu_z);

`ifdef ALU_ISSUE_TAG_EN
  logic [TAG_W-1:0] r_tag_in;
  logic [TAG_W-1:0] r_tag_cur;

  assign w_if_din = {r_tag_in, in_instr};
  assign w_rf_din = {r_tag_cur, w_result};
  assign out_tag  = w_rf_head[RF_W-1 -: TAG_W];

  // Tag assigned at accept (drops included); in-flight tag latched at issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_in  <= '0;
      r_tag_cur <= '0;
    end else begin
      if (w_if_push) r_tag_in  <= r_tag_in + 8'd1;
      if (w_issue)   r_tag_cur <= w_if_head[IF_W-1 -: TAG_W];
    end
  end
`else
  assign w_if_din = in_instr;
  assign w_rf_din = w_result;
`endif

  alu_issue_fifo #(.WIDTH(IF_W), .DEPTH(DEPTH)) u_instr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_if_push),
    .i_data  (w_if_din),
    .i_pop   (w_if_pop),
    .o_data  (w_if_head),
    .o_full  (w_if_full),
    .o_empty (w_if_empty)
  );

  alu_issue_fifo #(.WIDTH(RF_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rf_push),
    .i_data  (w_rf_din),
    .i_pop   (w_rf_pop),
    .o_data  (w_rf_head),
    .o_full  (w_rf_full),
    .o_empty (w_rf_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Issue only when the result FIFO has room, so the capture can never block.
  always_comb begin
    w_state_nxt = r_state;
    w_if_pop    = 1'b0;
    w_issue     = 1'b0;
    w_drop      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_if_empty && !w_rf_full) begin
          w_if_pop = 1'b1;
          if (w_legal) begin
            w_issue     = 1'b1;
            w_state_nxt = WAIT;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 2'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ALU instruction register and settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_instr <= '0;
      r_cnt       <= 2'd0;
    end else if (w_issue) begin
      r_alu_instr <= w_head_instr;
      r_cnt       <= LAT_M1;
    end else if (r_state == WAIT && r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  // Sticky error and drop counter; a drop in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_err      <= 1'b1;
      r_drop_cnt <= clr_err ? 8'd1 : sat_inc8(r_drop_cnt);
    end else if (clr_err) begin
      r_err      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end
  end

  assign in_ready   = !w_if_full;
  assign out_valid  = !w_rf_empty;
  assign out_data   = w_rf_head[RES_W-1:0];
  assign alu_instr  = r_alu_instr;
  assign busy       = (r_state == WAIT);
  assign err_opcode = r_err;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: one instance with ALU_LAT=1 driven through a
// scoreboard, one with ALU_LAT=3 for settle-time and mid-WAIT reset checks.
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1 (ALU_LAT = 1)
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy, err_opcode, clr_err;
  logic [19:0] in_instr, alu_instr;
  logic [7:0]  alu_y, drop_cnt;
  logic        alu_c, alu_v, alu_n, alu_z;
  logic [15:0] out_data;
  logic [7:0]  out_tag;

  // Instance 3 (ALU_LAT = 3)
  logic        rst3, in_valid3, in_ready3, out_valid3, out_ready3, busy3, err3, clr3;
  logic [19:0] in_instr3, alu_instr3;
  logic [7:0]  alu_y3, drop3;
  logic        alu_c3, alu_v3, alu_n3, alu_z3;
  logic [15:0] out_data3;
  logic [7:0]  out_tag3;
  logic [11:0] w_m3;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [15:0] data; logic [7:0] tag; } exp_t;
  exp_t       sb_q[$];
  logic [7:0] tb_tag;
  int         out_idx;

  typedef struct { logic [19:0] ins; logic legal; logic [15:0] exp; } vec_t;
  vec_t vt[12];

  // Reference ALU: {Y, C, V, N, Z}. C is carry / no-borrow.
  function automatic logic [11:0] alu_model(input logic [19:0] ins);
    logic [3:0] op;
    logic [7:0] a, b, y;
    logic [8:0] s;
    logic       c, v;
    op = ins[19:16]; a = ins[15:8]; b = ins[7:0];
    c = 1'b0; v = 1'b0; s = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b};        y = s[7:0]; c = s[8];
                  v = (a[7] == b[7]) && (y[7] != a[7]); end
      4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; y = s[7:0]; c = s[8];
                  v = (a[7] != b[7]) && (y[7] != a[7]); end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      default: y = a;
    endcase
    return {y, c, v, y[7], (y == 8'd0)};
  endfunction

  assign {alu_y, alu_c, alu_v, alu_n, alu_z} = alu_model(alu_instr);

  // Instance 3 ALU returns garbage Y until alu_instr has been stable 2 negedges.
  logic [19:0] last3 = '0;
  int          age3  = 0;
  always @(negedge clk) begin
    if (alu_instr3 !== last3) begin
      last3 <= alu_instr3;
      age3  <= 0;
    end else if (age3 < 7) begin
      age3 <= age3 + 1;
    end
  end
  assign w_m3 = alu_model(alu_instr3);
  assign alu_y3 = (age3 >= 2) ? w_m3[11:4] : 8'hEE;
  assign {alu_c3, alu_v3, alu_n3, alu_z3} = w_m3[3:0];

  alu_issue_unit #(.DEPTH(8), .ALU_LAT(1), .MAX_OP(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_instr(alu_instr), .alu_y(alu_y), .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n),
    .alu_z(alu_z), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef ALU_ISSUE_TAG_EN
    .out_tag(out_tag),
`endif
    .busy(busy), .err_opcode(err_opcode), .drop_cnt(drop_cnt), .clr_err(clr_err)
  );

  alu_issue_unit #(.DEPTH(8), .ALU_LAT(3), .MAX_OP(8)) u_dut3 (
    .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3), .in_instr(in_instr3),
    .alu_instr(alu_instr3), .alu_y(alu_y3), .alu_c(alu_c3), .alu_v(alu_v3), .alu_n(alu_n3),
    .alu_z(alu_z3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
`ifdef ALU_ISSUE_TAG_EN
    .out_tag(out_tag3),
`endif
    .busy(busy3), .err_opcode(err3), .drop_cnt(drop3), .clr_err(clr3)
  );

`ifndef ALU_ISSUE_TAG_EN
  assign out_tag  = 8'd0;
  assign out_tag3 = 8'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard: compare every completed output transfer against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got %0h want none", out_data);
      end else begin
        e = sb_q.pop_front();
        chk("out_data", out_data, e.data);
`ifdef ALU_ISSUE_TAG_EN
        chk("out_tag", out_tag, e.tag);
        if (out_idx == 0)   chk("tag_first", out_tag, 8'h00);
        if (out_idx == 255) chk("tag_256th", out_tag, 8'hFF);
        if (out_idx == 256) chk("tag_257th", out_tag, 8'h00);
`endif
      end
      out_idx++;
    end
  end

  task automatic push(input logic [19:0] ins, input logic want, input logic [15:0] exp_d);
    int n = 0;
    in_instr = ins;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("push_ready", in_ready, 1);
    if (in_ready) begin
      if (want) sb_q.push_back('{data: exp_d, tag: tb_tag});
      tb_tag++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic push_model(input logic [19:0] ins);
    push(ins, 1'b1, {ins[19:16], alu_model(ins)});
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push3(input logic [19:0] ins);
    in_instr3 = ins;
    in_valid3 = 1'b1;
    @(negedge clk);
    chk("push3_ready", in_ready3, 1);
    @(posedge clk);
    #1 in_valid3 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, busy_n, unstable, first_ov;
    logic [19:0] r_ins;

    vt[0]  = '{20'h02814, 1'b1, 16'h03C0};
    vt[1]  = '{20'h0FF01, 1'b1, 16'h0009};
    vt[2]  = '{20'h07F01, 1'b1, 16'h0806};
    vt[3]  = '{20'h11020, 1'b1, 16'h1F02};
    vt[4]  = '{20'h15555, 1'b1, 16'h1009};
    vt[5]  = '{20'h2F03C, 1'b1, 16'h2300};
    vt[6]  = '{20'h30FA0, 1'b1, 16'h3AF2};
    vt[7]  = '{20'h4AAAA, 1'b1, 16'h4001};
    vt[8]  = '{20'h88100, 1'b1, 16'h8812};
    vt[9]  = '{20'h91234, 1'b0, 16'h0000};
    vt[10] = '{20'hF0000, 1'b0, 16'h0000};
    vt[11] = '{20'h50000, 1'b1, 16'h5001};

    rst = 1'b1; rst3 = 1'b1;
    in_valid = 1'b0; in_instr = '0; out_ready = 1'b1; clr_err = 1'b0;
    in_valid3 = 1'b0; in_instr3 = '0; out_ready3 = 1'b0; clr3 = 1'b0;
    tb_tag = '0; out_idx = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("rst_alu_instr", alu_instr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_opcode, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;

    // Single instruction: value and accept-to-out_valid latency.
    push(vt[0].ins, 1'b1, vt[0].exp);
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, 3);
    wait_drain(50);

    // Table of vectors, back to back, including illegal opcodes.
    for (int i = 0; i < 12; i++) push(vt[i].ins, vt[i].legal, vt[i].exp);
    wait_drain(100);
    chk("err_after_drops", err_opcode, 1);
    chk("drop_cnt_2", drop_cnt, 2);

    clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    chk("clr_err_flag", err_opcode, 0);
    chk("clr_drop_cnt", drop_cnt, 0);

    // Drop coinciding with clr_err: the drop wins.
    push(20'hA0000, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1 chk("drop_cnt_1", drop_cnt, 1);
    clr_err = 1'b1;
    push(20'hB0000, 1'b0, 16'h0);
    @(posedge clk); #1 clr_err = 1'b0;
    chk("drop_clr_err", err_opcode, 1);
    chk("drop_clr_cnt", drop_cnt, 1);

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) push(20'hC0000, 1'b0, 16'h0);
    repeat (4) @(posedge clk);
    #1 chk("drop_cnt_sat", drop_cnt, 255);

    // Backpressure: 16 queued with out_ready low, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r_ins = {4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom)};
      push_model(r_ins);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_busy", busy, 0);
    chk("bp_pending", sb_q.size(), 16);
    out_ready = 1'b1;
    wait_drain(200);

    // ALU_LAT = 3: hold time, busy length, no early capture.
    push3(20'h02814);
    busy_n = 0; unstable = 0; first_ov = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (busy3) busy_n++;
      if (busy3 && alu_instr3 !== 20'h02814) unstable++;
      if (out_valid3 && first_ov == 0) first_ov = k;
    end
    chk("lat3_busy_cycles", busy_n, 3);
    chk("lat3_stable", unstable, 0);
    chk("lat3_outv_edge", first_ov, 4);
    chk("lat3_out_data", out_data3, 16'h03C0);

    // Reset during WAIT discards everything.
    push3(20'h11020);
    @(posedge clk); #1;
    chk("lat3_in_wait", busy3, 1);
    rst3 = 1'b1;
    #1;
    chk("rstw_alu_instr", alu_instr3, 0);
    chk("rstw_out_valid", out_valid3, 0);
    chk("rstw_busy", busy3, 0);
    @(posedge clk); #1 rst3 = 1'b0;
    push3(20'h2F03C);
    edges = 0;
    while (!out_valid3 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("post_rst_valid", out_valid3, 1);
    chk("post_rst_data", out_data3, 16'h2300);

`ifdef ALU_ISSUE_TAG_EN
    // Tag wrap over 257 instructions, then a drop consuming a tag.
    @(posedge clk); #1 rst = 1'b1;
    sb_q.delete(); tb_tag = '0; out_idx = 0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 257; i++) push_model({4'(i % 5), 8'(i), 8'(i * 3)});
    wait_drain(400);
    push(20'h9FFFF, 1'b0, 16'h0);
    push_model(20'h01234);
    wait_drain(50);
`endif

    chk("sb_final", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
